// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serial memory arbiter: access sizes,
// FSM states and the size-to-byte-count mapping.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Encoding 11 is handled as a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: fixed priority (highest index wins) or round-robin
// starting just above the last-granted index.
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int RR    = 0,
  parameter int PW    = 1
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NPORT-1:0] gnt
);

  int idx;

  always_comb begin
    gnt = '0;
    idx = 0;
    if (RR == 0) begin
      for (int i = 0; i < NPORT; i++) begin
        if (req[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
        end
      end
    end else begin
      // Walk from the farthest offset down so the nearest requester lands last.
      for (int j = NPORT; j >= 1; j--) begin
        idx = (int'(ptr) + j) % NPORT;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Multi-port arbiter serialising byte/halfword/word accesses onto a
// single byte-wide RAM with a fixed read latency.
//
// state    | meaning
// ST_IDLE  | arbitrate among requesters; done pulses here
// ST_XFER  | issue one byte address (and write data) per cycle
// ST_DRAIN | read addresses issued, waiting for last byte to return
module mem_arb
  import mem_pkg::*;
#(
  parameter int NPORT  = 2,
  parameter int AW     = 32,
  parameter int RD_LAT = 1,
  parameter int RR     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT-1:0]    wr,
  input  logic [2*NPORT-1:0]  size,
  input  logic [AW*NPORT-1:0] addr,
  input  logic [32*NPORT-1:0] wdata,
  input  logic [NPORT-1:0]    cancel,
  output logic [NPORT-1:0]    done,
  output logic [31:0]         rdata,
  input  logic [7:0]          ram_din,
  output logic [7:0]          ram_dout,
  output logic [AW-1:0]       ram_a,
  output logic                ram_wr,
  output logic                busy
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_t                   state;
  logic [PW-1:0]            owner, ptr, sel_idx;
  logic                     wr_q;
  logic [1:0]               size_q, k, nk, last_k;
  logic [2:0]               nbytes;
  logic [AW-1:0]            addr_q;
  logic [31:0]              wdata_q, rbuf, cap_buf;
  logic [NPORT-1:0]         cand, gnt;
  logic                     own_cancel, cap_last;
  logic [RD_LAT-1:0]        pipe_v;
  logic [RD_LAT-1:0][1:0]   pipe_k;

  mem_arb_pick #(.NPORT(NPORT), .RR(RR), .PW(PW)) u_pick (
    .req (cand),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    // A port finishing this cycle must not be re-granted on its stale request.
    cand    = req & ~done;
    sel_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (gnt[i]) sel_idx = PW'(i);
    end
    nbytes     = size_bytes(size_q);
    last_k     = 2'(nbytes - 3'd1);
    nk         = k + 2'd1;
    own_cancel = cancel[owner] && !wr_q;
    cap_buf    = rbuf;
    if (pipe_v[RD_LAT-1]) cap_buf[{pipe_k[RD_LAT-1], 3'b000} +: 8] = ram_din;
    cap_last   = pipe_v[RD_LAT-1] && (pipe_k[RD_LAT-1] == last_k);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      ptr      <= PW'(NPORT - 1);
      wr_q     <= 1'b0;
      size_q   <= SZ_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      k        <= '0;
      rbuf     <= '0;
      rdata    <= '0;
      done     <= '0;
      ram_a    <= '0;
      ram_wr   <= 1'b0;
      ram_dout <= '0;
      pipe_v   <= '0;
      pipe_k   <= '0;
    end else begin
      done      <= '0;
      rbuf      <= cap_buf;
      pipe_v[0] <= (state == ST_XFER) && !wr_q;
      pipe_k[0] <= k;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_k[i] <= pipe_k[i-1];
      end
      case (state)
        ST_IDLE: begin
          if (|cand) begin
            state    <= ST_XFER;
            owner    <= sel_idx;
            ptr      <= sel_idx;
            wr_q     <= wr[sel_idx];
            size_q   <= size[2*sel_idx +: 2];
            addr_q   <= addr[AW*sel_idx +: AW];
            wdata_q  <= wdata[32*sel_idx +: 32];
            k        <= '0;
            rbuf     <= '0;
            ram_a    <= addr[AW*sel_idx +: AW];
            ram_wr   <= wr[sel_idx];
            ram_dout <= wdata[32*sel_idx +: 8];
          end
        end
        ST_XFER: begin
          if (own_cancel) begin
            state    <= ST_IDLE;
            pipe_v   <= '0;
            ram_a    <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= '0;
          end else if (k == last_k) begin
            state    <= wr_q ? ST_IDLE : ST_DRAIN;
            ram_a    <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= '0;
            if (wr_q) done[owner] <= 1'b1;
          end else begin
            k        <= nk;
            ram_a    <= addr_q + AW'(nk);
            ram_dout <= wdata_q[{nk, 3'b000} +: 8];
          end
        end
        ST_DRAIN: begin
          if (own_cancel) begin
            state  <= ST_IDLE;
            pipe_v <= '0;
          end else if (cap_last) begin
            state       <= ST_IDLE;
            done[owner] <= 1'b1;
            rdata       <= cap_buf;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: table of single transfers plus hand-written
// contention, cancel, reset and round-robin sequences.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, req1, wr, cancel;
  logic [3:0]  size;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  done, done1;
  logic [31:0] rdata, rdata1;
  logic [7:0]  ram_din, ram_dout, ram_din1, ram_dout1;
  logic [31:0] ram_a, ram_a1;
  logic        ram_wr, ram_wr1, busy, busy1;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  mem_arb #(.NPORT(2), .AW(32), .RD_LAT(1), .RR(0)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .cancel(cancel), .done(done), .rdata(rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .busy(busy)
  );

  mem_arb #(.NPORT(2), .AW(32), .RD_LAT(1), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req1), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .cancel(cancel), .done(done1), .rdata(rdata1),
    .ram_din(ram_din1), .ram_dout(ram_dout1), .ram_a(ram_a1), .ram_wr(ram_wr1),
    .busy(busy1)
  );

  // RAM model with one cycle of read latency, plus a log of every write.
  logic [7:0]  mem [0:1023];
  logic [39:0] wlog [$];

  assign ram_din1 = 8'h00;

  always @(posedge clk) begin
    ram_din <= mem[ram_a[9:0]];
    if (ram_wr) begin
      mem[ram_a[9:0]] <= ram_dout;
      wlog.push_back({ram_a, ram_dout});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
    wr[p]          = w;
    size[2*p +: 2] = sz;
    addr[32*p +: 32]  = a;
    wdata[32*p +: 32] = d;
  endtask

  typedef struct {
    int          port;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  cx;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[12];

  initial begin
    int lat, n, t0, t1, nd, cnt, c;
    logic got;
    logic [1:0] exp_rr [4];

    vt[0]  = '{1, 1'b1, 2'b10, 32'h0000_0100, 32'hA1B2_C3D4, 2'b00, 5, 32'h0};
    vt[1]  = '{0, 1'b1, 2'b00, 32'h0000_0200, 32'h0000_0080, 2'b00, 2, 32'h0};
    vt[2]  = '{1, 1'b1, 2'b01, 32'h0000_0201, 32'h0000_0201, 2'b00, 3, 32'h0};
    vt[3]  = '{0, 1'b1, 2'b00, 32'h0000_0203, 32'hFFFF_FF03, 2'b00, 2, 32'h0};
    vt[4]  = '{0, 1'b0, 2'b01, 32'h0000_0200, 32'h0,         2'b00, 4, 32'h0000_0180};
    vt[5]  = '{1, 1'b0, 2'b10, 32'h0000_0200, 32'h0,         2'b00, 6, 32'h0302_0180};
    vt[6]  = '{0, 1'b0, 2'b00, 32'h0000_0201, 32'h0,         2'b00, 3, 32'h0000_0001};
    vt[7]  = '{1, 1'b1, 2'b10, 32'hFFFF_FFFE, 32'h4433_2211, 2'b00, 5, 32'h0};
    vt[8]  = '{0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         2'b00, 6, 32'h4433_2211};
    vt[9]  = '{1, 1'b0, 2'b11, 32'h0000_0200, 32'h0,         2'b01, 6, 32'h0302_0180};
    vt[10] = '{0, 1'b1, 2'b01, 32'h0000_0204, 32'h0000_BEEF, 2'b01, 3, 32'h0};
    vt[11] = '{1, 1'b0, 2'b01, 32'h0000_0204, 32'h0,         2'b00, 4, 32'h0000_BEEF};
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst = 1'b1; req = '0; req1 = '0; wr = '0; cancel = '0;
    size = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_done",  64'(done),     64'h0);
    chk("rst_busy",  64'(busy),     64'h0);
    chk("rst_ramwr", 64'(ram_wr),   64'h0);
    chk("rst_rama",  64'(ram_a),    64'h0);
    chk("rst_dout",  64'(ram_dout), 64'h0);
    chk("rst_rdata", 64'(rdata),    64'h0);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      set_port(vt[v].port, vt[v].w, vt[v].sz, vt[v].a, vt[v].d);
      cancel = vt[v].cx;
      req[vt[v].port] = 1'b1;
      wlog.delete();
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
        @(negedge clk);
        lat++;
        if (done != 2'b00) got = 1'b1;
      end
      chk($sformatf("v%0d_lat", v), 64'(lat), 64'(vt[v].lat));
      chk($sformatf("v%0d_done", v), 64'(done), 64'(2'b01 << vt[v].port));
      if (!vt[v].w) chk($sformatf("v%0d_rdata", v), 64'(rdata), 64'(vt[v].rd));
      req = '0; cancel = '0;
      @(negedge clk);
      chk($sformatf("v%0d_idle", v), {61'h0, busy, ram_wr, done != 2'b00}, 64'h0);
      chk($sformatf("v%0d_idle_a", v), 64'(ram_a), 64'h0);
      if (!vt[v].w) chk($sformatf("v%0d_hold", v), 64'(rdata), 64'(vt[v].rd));
      if (vt[v].w) begin
        n = (vt[v].sz == 2'b00) ? 1 : (vt[v].sz == 2'b01) ? 2 : 4;
        chk($sformatf("v%0d_nwr", v), 64'(wlog.size()), 64'(n));
        for (int b = 0; b < n && b < wlog.size(); b++)
          chk($sformatf("v%0d_wb%0d", v, b), 64'(wlog[b]),
              64'({vt[v].a + 32'(b), vt[v].d[8*b +: 8]}));
      end
    end

    // Fixed priority: port 1 first, port 0 granted at the end of done[1]'s cycle.
    set_port(0, 1'b0, 2'b00, 32'h0000_0200, 32'h0);
    set_port(1, 1'b1, 2'b00, 32'h0000_0206, 32'h0000_0055);
    req = 2'b11;
    t0 = -1; t1 = -1;
    for (int cy = 1; cy <= 20 && (t0 < 0 || t1 < 0); cy++) begin
      @(negedge clk);
      if (done[0]) begin
        t0 = cy;
        chk("cont_rdata", 64'(rdata), 64'h80);
        req[0] = 1'b0;
      end
      if (done[1]) begin
        t1 = cy;
        req[1] = 1'b0;
      end
    end
    chk("cont_t1", 64'(t1), 64'd2);
    chk("cont_t0", 64'(t0), 64'd5);
    req = '0;
    @(negedge clk);

    // Owner cancel on the second byte of a word read.
    set_port(0, 1'b0, 2'b10, 32'h0000_0200, 32'h0);
    req = 2'b01;
    repeat (2) @(negedge clk);
    chk("cxl_a", 64'(ram_a), 64'h201);
    chk("cxl_busy_pre", 64'(busy), 64'h1);
    cancel = 2'b01;
    @(negedge clk);
    chk("cxl_idle", 64'(busy), 64'h0);
    chk("cxl_done", 64'(done), 64'h0);
    cancel = '0; req = '0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done != 2'b00 || busy) nd++;
    end
    chk("cxl_quiet", 64'(nd), 64'h0);

    // Reset during the third byte of a word write.
    set_port(1, 1'b1, 2'b10, 32'h0000_0300, 32'hCAFE_F00D);
    req = 2'b10;
    repeat (3) @(negedge clk);
    chk("rstx_a", 64'(ram_a), 64'h302);
    chk("rstx_wr", 64'(ram_wr), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstx_wr0", 64'(ram_wr), 64'h0);
    chk("rstx_busy", 64'(busy), 64'h0);
    chk("rstx_done", 64'(done), 64'h0);
    rst = 1'b0; req = '0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done != 2'b00) nd++;
    end
    chk("rstx_quiet", 64'(nd), 64'h0);

    // Round-robin with both ports holding requests (pointer freshly reset).
    set_port(0, 1'b1, 2'b00, 32'h0000_0010, 32'h0000_0011);
    set_port(1, 1'b1, 2'b00, 32'h0000_0011, 32'h0000_0022);
    req1 = 2'b11;
    cnt = 0; c = 0;
    while (cnt < 4 && c < 40) begin
      @(negedge clk);
      c++;
      if (done1 != 2'b00) begin
        chk($sformatf("rr_g%0d", cnt), 64'(done1), 64'(exp_rr[cnt]));
        chk($sformatf("rr_t%0d", cnt), 64'(c), 64'(2 * (cnt + 1)));
        cnt++;
      end
    end
    chk("rr_count", 64'(cnt), 64'd4);
    req1 = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
